// File: rtl/apb_upsizer_16to32_if.sv
// apb_upsizer_16to32_if: 16-bit upstream and 32-bit downstream APB signals of the upsizer.
interface apb_upsizer_16to32_if;
    logic        pwrite_m_i;
    logic        psel_m_i;
    logic        penable_m_i;
    logic [15:0] pwdata_m_i;
    logic [15:0] prdata_m_o;
    logic [31:0] paddr_m_i;
    logic [1:0]  pstrb_m_i;
    logic        pready_m_o;
    logic        pwrite_s_o;
    logic        psel_s_o;
    logic        penable_s_o;
    logic [31:0] pwdata_s_o;
    logic [31:0] prdata_s_i;
    logic [31:0] paddr_s_o;
    logic [3:0]  pstrb_s_o;
    logic        pready_s_i;

    modport slave (
        input  pwrite_m_i, psel_m_i, penable_m_i, pwdata_m_i, paddr_m_i, pstrb_m_i,
        output prdata_m_o, pready_m_o,
        output pwrite_s_o, psel_s_o, penable_s_o, pwdata_s_o, paddr_s_o, pstrb_s_o,
        input  prdata_s_i, pready_s_i
    );

    modport master (
        output pwrite_m_i, psel_m_i, penable_m_i, pwdata_m_i, paddr_m_i, pstrb_m_i,
        input  prdata_m_o, pready_m_o,
        input  pwrite_s_o, psel_s_o, penable_s_o, pwdata_s_o, paddr_s_o, pstrb_s_o,
        output prdata_s_i, pready_s_i
    );
endinterface

// File: rtl/apb_upsizer_16to32.sv
// apb_upsizer_16to32: re-issues each 16-bit APB transfer as one registered 32-bit APB transfer.
module apb_upsizer_16to32 (
    input logic pclk,
    input logic prst,
    apb_upsizer_16to32_if.slave bus
);
    typedef enum logic [1:0] {IDLE, S_SETUP, S_ACCESS, M_DONE} state_t;

    state_t      r_state, w_next;
    logic        w_capture, w_rd_done;
    logic        r_lane, r_pwrite, r_psel, r_penable, r_pready;
    logic [31:0] r_paddr, r_pwdata;
    logic [3:0]  r_pstrb;
    logic [15:0] r_prdata;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_capture = (r_state == IDLE) && bus.psel_m_i && !bus.penable_m_i;
        w_rd_done = (r_state == S_ACCESS) && bus.pready_s_i && !r_pwrite;
        w_next    = (r_state == IDLE)     ? (w_capture ? S_SETUP : IDLE) :
                    (r_state == S_SETUP)  ? S_ACCESS :
                    (r_state == S_ACCESS) ? (bus.pready_s_i ? M_DONE : S_ACCESS) : IDLE;
    end

    // Bus controls are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_lane    <= 1'b0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pready  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_prdata  <= '0;
        end else begin
            r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_penable <= (w_next == S_ACCESS);
            r_pready  <= (w_next == M_DONE);
            if (w_capture) begin
                r_lane   <= bus.paddr_m_i[1];
                r_pwrite <= bus.pwrite_m_i;
                r_paddr  <= bus.paddr_m_i & ~32'h3;
                r_pwdata <= {bus.pwdata_m_i, bus.pwdata_m_i};
                r_pstrb  <= !bus.pwrite_m_i ? 4'b0000 :
                            bus.paddr_m_i[1] ? {bus.pstrb_m_i, 2'b00} : {2'b00, bus.pstrb_m_i};
            end
            if (w_rd_done) r_prdata <= r_lane ? bus.prdata_s_i[31:16] : bus.prdata_s_i[15:0];
        end
    end

    assign bus.prdata_m_o  = r_prdata;
    assign bus.pready_m_o  = r_pready;
    assign bus.pwrite_s_o  = r_pwrite;
    assign bus.psel_s_o    = r_psel;
    assign bus.penable_s_o = r_penable;
    assign bus.pwdata_s_o  = r_pwdata;
    assign bus.paddr_s_o   = r_paddr;
    assign bus.pstrb_s_o   = r_pstrb;
endmodule

// File: tb/tb_apb_upsizer_16to32.sv
// tb_apb_upsizer_16to32: directed and random APB transfers checked against a rule-level model.
module tb_apb_upsizer_16to32;
    logic pclk = 1'b0;
    logic prst = 1'b1;
    apb_upsizer_16to32_if bus();

    apb_upsizer_16to32 dut (.pclk(pclk), .prst(prst), .bus(bus));

    always #5 pclk = ~pclk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_waits = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          setup_cyc = 0;
    logic [15:0] model_rdata = '0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Downstream completer: holds pready low for resp_waits access cycles, then completes.
    initial begin
        bus.pready_s_i = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.psel_s_o && bus.penable_s_o) begin
                bus.pready_s_i = (acc_cnt >= resp_waits);
                acc_cnt++;
            end else begin
                bus.pready_s_i = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    task automatic run_xfer(input logic w, input logic [31:0] addr, input logic [15:0] data,
                            input logic [1:0] strb, input logic [31:0] rd, input int waits);
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        int          k;
        e_addr  = addr - (addr % 4);
        e_wdata = {data, data};
        e_strb  = !w ? 4'd0 : addr[1] ? 4'(strb) * 4'd4 : 4'(strb);
        if (!w) model_rdata = addr[1] ? rd[31:16] : rd[15:0];
        resp_waits = waits;
        bus.prdata_s_i = rd;
        bus.psel_m_i = 1'b1;
        bus.penable_m_i = 1'b0;
        bus.pwrite_m_i = w;
        bus.paddr_m_i = addr;
        bus.pwdata_m_i = data;
        bus.pstrb_m_i = strb;
        @(posedge pclk);
        #1;
        setup_cyc = cyc;
        bus.penable_m_i = 1'b1;
        k = 0;
        while (1) begin
            @(negedge pclk);
            k++;
            if (bus.pready_m_o || k > 40) break;
            if (k == 1) begin
                if ({bus.psel_s_o, bus.penable_s_o} !== 2'b10) begin
                    n_fail++; $display("FAIL setup_ctrl got %b want 10", {bus.psel_s_o, bus.penable_s_o});
                end
                n_checks++;
                if ({bus.pwrite_s_o, bus.paddr_s_o, bus.pwdata_s_o, bus.pstrb_s_o} !== {w, e_addr, e_wdata, e_strb}) begin
                    n_fail++;
                    $display("FAIL req got w=%b a=%h d=%h s=%b want w=%b a=%h d=%h s=%b", bus.pwrite_s_o,
                             bus.paddr_s_o, bus.pwdata_s_o, bus.pstrb_s_o, w, e_addr, e_wdata, e_strb);
                end
                n_checks++;
            end else begin
                if ({bus.psel_s_o, bus.penable_s_o} !== 2'b11) begin
                    n_fail++; $display("FAIL access_ctrl k=%0d got %b want 11", k, {bus.psel_s_o, bus.penable_s_o});
                end
                n_checks++;
            end
        end
        if (k !== 3 + waits) begin
            n_fail++; $display("FAIL latency got %0d want %0d", k, 3 + waits);
        end
        n_checks++;
        if (bus.prdata_m_o !== model_rdata) begin
            n_fail++; $display("FAIL prdata got %h want %h", bus.prdata_m_o, model_rdata);
        end
        n_checks++;
        if ({bus.psel_s_o, bus.penable_s_o} !== 2'b00) begin
            n_fail++; $display("FAIL done_ctrl got %b want 00", {bus.psel_s_o, bus.penable_s_o});
        end
        n_checks++;
        @(posedge pclk);
        #1;
        bus.psel_m_i = 1'b0;
        bus.penable_m_i = 1'b0;
        if (bus.pready_m_o !== 1'b0) begin
            n_fail++; $display("FAIL pready_pulse got %b want 0", bus.pready_m_o);
        end
        n_checks++;
    endtask

    task automatic check_all_zero(input string tag);
        if ({bus.prdata_m_o, bus.pready_m_o, bus.pwrite_s_o, bus.psel_s_o, bus.penable_s_o,
             bus.pwdata_s_o, bus.paddr_s_o, bus.pstrb_s_o} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs got rd=%h rdy=%b w=%b sel=%b en=%b d=%h a=%h s=%b want all 0", tag,
                     bus.prdata_m_o, bus.pready_m_o, bus.pwrite_s_o, bus.psel_s_o, bus.penable_s_o,
                     bus.pwdata_s_o, bus.paddr_s_o, bus.pstrb_s_o);
        end
        n_checks++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1;
        check_all_zero("reset");
        @(negedge pclk);
        prst = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_directed();
        run_xfer(1'b1, 32'h0, 16'h6689, 2'b11, 32'h0, 0);
        run_xfer(1'b1, 32'h2, 16'h6677, 2'b11, 32'h0, 0);
        run_xfer(1'b0, 32'h4, 16'h0, 2'b00, 32'h99998888, 0);
        run_xfer(1'b0, 32'h6, 16'h0, 2'b00, 32'h99998888, 2);
        run_xfer(1'b1, 32'h12, 16'hA55A, 2'b01, 32'h0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_xfer(1'($urandom), $urandom, 16'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int first;
        run_xfer(1'b1, 32'h40, 16'h1234, 2'b10, 32'h0, 0);
        first = setup_cyc;
        run_xfer(1'b0, 32'h42, 16'h0, 2'b00, 32'hCAFEBEEF, 0);
        if (setup_cyc - first !== 4) begin
            n_fail++; $display("FAIL b2b_period got %0d want 4", setup_cyc - first);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        resp_waits = 10;
        bus.psel_m_i = 1'b1;
        bus.penable_m_i = 1'b0;
        bus.pwrite_m_i = 1'b0;
        bus.paddr_m_i = 32'h8;
        @(posedge pclk);
        #1;
        bus.penable_m_i = 1'b1;
        @(posedge pclk);
        #1;
        if ({bus.psel_s_o, bus.penable_s_o} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_ctrl got %b want 11", {bus.psel_s_o, bus.penable_s_o});
        end
        n_checks++;
        #2;
        prst = 1'b1;
        #1;
        model_rdata = '0;
        check_all_zero("mid_reset");
        bus.psel_m_i = 1'b0;
        bus.penable_m_i = 1'b0;
        @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        if (bus.psel_s_o !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got %b want 0", bus.psel_s_o);
        end
        n_checks++;
        run_xfer(1'b0, 32'h6, 16'h0, 2'b00, 32'h5A5AC3C3, 1);
    endtask

    task automatic test_no_capture();
        bus.psel_m_i = 1'b1;
        bus.penable_m_i = 1'b1;
        bus.pwrite_m_i = 1'b1;
        bus.paddr_m_i = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if ({bus.psel_s_o, bus.pready_m_o} !== 2'b00) begin
                n_fail++; $display("FAIL no_capture got %b want 00", {bus.psel_s_o, bus.pready_m_o});
            end
            n_checks++;
        end
        bus.psel_m_i = 1'b0;
        bus.penable_m_i = 1'b0;
        @(negedge pclk);
    endtask

    initial begin
        bus.psel_m_i = 1'b0;
        bus.penable_m_i = 1'b0;
        bus.pwrite_m_i = 1'b0;
        bus.paddr_m_i = '0;
        bus.pwdata_m_i = '0;
        bus.pstrb_m_i = '0;
        bus.prdata_s_i = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_no_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
